// File: rtl/prime_factorizer_if.sv
// Start/result handshake between a prime_factorizer and its user.
// The user drives go/n/next; the factorizer answers with status and one factor at a time.
interface prime_factorizer_if #(
  parameter int WIDTH = 16
);
  logic             go;
  logic [WIDTH-1:0] n;
  logic             next;
  logic             ready;
  logic             valid;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] factor;

  modport master (
    output go, n, next,
    input  ready, valid, done, error, factor
  );

  modport slave (
    input  go, n, next,
    output ready, valid, done, error, factor
  );
endinterface

// File: rtl/prime_factorizer.sv
// Streams the prime factorisation of an unsigned integer in nondecreasing order,
// using trial division by 2, 3, 5, 7, ... through a serial restoring divider.
module prime_factorizer #(
  parameter int WIDTH_LOG = 4
) (
  input  logic               clk,
  input  logic               rst,
  prime_factorizer_if.slave  bus
);
  localparam int WIDTH = 1 << WIDTH_LOG;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DIV,
    EMIT,
    EMIT_LAST
  } state_t;

  state_t               state_q;
  logic                 ready_q;
  logic                 valid_q;
  logic                 done_q;
  logic                 error_q;
  logic [WIDTH-1:0]     factor_q;

  logic [WIDTH-1:0]     m_q;
  logic [WIDTH-1:0]     d_q;
  logic [WIDTH+1:0]     dsq_q;

  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     quot_q;
  logic [WIDTH_LOG-1:0] cnt_q;

  logic [WIDTH:0]       shifted_rem;
  logic [WIDTH:0]       trial_rem;
  logic                 take;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     quot_d;
  logic [WIDTH+1:0]     dsq_d;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  // The remainder is always below d, so WIDTH bits hold it between steps.
  always_comb begin
    shifted_rem = {rem_q, quot_q[WIDTH-1]};
    trial_rem   = shifted_rem - {1'b0, d_q};
    take        = (shifted_rem >= {1'b0, d_q});
    rem_d       = take ? trial_rem[WIDTH-1:0] : shifted_rem[WIDTH-1:0];
    quot_d      = {quot_q[WIDTH-2:0], take};
    dsq_d       = dsq_q + {d_q, 2'b00} + (WIDTH+2)'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      factor_q <= '0;
      m_q      <= '0;
      d_q      <= '0;
      dsq_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.go) begin
            m_q     <= bus.n;
            done_q  <= (bus.n == WIDTH'(1));
            error_q <= (bus.n == '0);
            if (bus.n > WIDTH'(1)) begin
              d_q     <= WIDTH'(2);
              dsq_q   <= (WIDTH+2)'(4);
              ready_q <= 1'b0;
              state_q <= CHECK;
            end
          end
        end

        CHECK: begin
          // Once d*d exceeds the cofactor, whatever is left is itself prime.
          if (dsq_q > {2'b00, m_q}) begin
            if (m_q == WIDTH'(1)) begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              factor_q <= m_q;
              valid_q  <= 1'b1;
              state_q  <= EMIT_LAST;
            end
          end else begin
            rem_q   <= '0;
            quot_q  <= m_q;
            cnt_q   <= '0;
            state_q <= DIV;
          end
        end

        DIV: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q + WIDTH_LOG'(1);
          if (&cnt_q) begin
            if (rem_d == '0) begin
              factor_q <= d_q;
              valid_q  <= 1'b1;
              m_q      <= quot_d;
              state_q  <= EMIT;
            end else begin
              // 2 is the only even trial divisor; (d+2)^2 = d^2 + 4d + 4 otherwise.
              if (d_q == WIDTH'(2)) begin
                d_q   <= WIDTH'(3);
                dsq_q <= (WIDTH+2)'(9);
              end else begin
                d_q   <= d_q + WIDTH'(2);
                dsq_q <= dsq_d;
              end
              state_q <= CHECK;
            end
          end
        end

        EMIT: begin
          if (bus.next) begin
            valid_q <= 1'b0;
            state_q <= CHECK;
          end
        end

        EMIT_LAST: begin
          if (bus.next) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.valid  = valid_q;
  assign bus.done   = done_q;
  assign bus.error  = error_q;
  assign bus.factor = factor_q;

endmodule

// File: tb/tb_prime_factorizer.sv
// Directed bench for prime_factorizer: expected factors are queued when a request
// is issued and compared in order as the factorizer presents them.
module tb_prime_factorizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] sb[$];

  prime_factorizer_if #(.WIDTH(16)) bus ();

  prime_factorizer #(.WIDTH_LOG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] val);
    @(negedge clk);
    check("ready_before_go", bus.ready, 1);
    bus.n  = val;
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    $display("go n=%0d", val);
  endtask

  // hold == 0: next tied high. hold > 0: next held low that many cycles per factor,
  // plus one stray next pulse while no factor is valid.
  task automatic collect(input int hold);
    int          cyc;
    bit          fin;
    bit          poke;
    logic [15:0] exp;
    cyc  = 0;
    fin  = 1'b0;
    poke = 1'b0;
    bus.next = (hold == 0);
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (bus.valid) begin
        check("factor_expected", sb.size() > 0, 1);
        exp = 16'h0;
        if (sb.size() > 0) exp = sb.pop_front();
        check("factor", bus.factor, exp);
        $display("factor %0d (expected %0d)", bus.factor, exp);
        if (hold > 0) begin
          for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            cyc++;
            check("bp_valid", bus.valid, 1);
            check("bp_factor", bus.factor, exp);
          end
          bus.next = 1'b1;
          @(negedge clk);
          cyc++;
          bus.next = 1'b0;
          check("consumed", bus.valid, 0);
          poke = 1'b1;
        end
      end else if (poke && !bus.done) begin
        bus.next = 1'b1;
        @(negedge clk);
        cyc++;
        bus.next = 1'b0;
        check("stray_next", bus.valid, 0);
        poke = 1'b0;
      end
      fin = bus.done;
    end
    bus.next = 1'b0;
    check("finished_in_budget", fin, 1);
    check("sb_empty", sb.size(), 0);
    check("done", bus.done, 1);
    check("ready_after", bus.ready, 1);
    check("error_after", bus.error, 0);
    check("valid_after", bus.valid, 0);
  endtask

  initial begin
    bus.go   = 1'b0;
    bus.n    = '0;
    bus.next = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_valid", bus.valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_factor", bus.factor, 0);
    rst = 1'b0;

    // Composite with multiplicity, next tied high.
    sb.push_back(16'd2); sb.push_back(16'd2); sb.push_back(16'd3);
    start(16'd12);
    check("busy_after_go", bus.ready, 0);
    collect(0);

    // Largest 16-bit prime.
    sb.push_back(16'd65521);
    start(16'd65521);
    collect(0);

    // Four distinct factors; a go while busy must be ignored.
    sb.push_back(16'd3); sb.push_back(16'd5); sb.push_back(16'd17); sb.push_back(16'd257);
    start(16'd65535);
    @(negedge clk);
    bus.n  = 16'd7;
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    check("busy_go_ignored", bus.ready, 0);
    collect(0);

    // n = 1: done immediately, nothing emitted.
    start(16'd1);
    check("n1_done", bus.done, 1);
    check("n1_ready", bus.ready, 1);
    check("n1_valid", bus.valid, 0);
    check("n1_error", bus.error, 0);

    // n = 0: error, stays idle.
    start(16'd0);
    check("n0_error", bus.error, 1);
    check("n0_done", bus.done, 0);
    check("n0_ready", bus.ready, 1);

    // A following request clears error.
    sb.push_back(16'd2); sb.push_back(16'd2);
    start(16'd4);
    check("n4_error_cleared", bus.error, 0);
    check("n4_done_cleared", bus.done, 0);
    collect(0);

    // Backpressure.
    sb.push_back(16'd2); sb.push_back(16'd3); sb.push_back(16'd3);
    start(16'd18);
    collect(10);

    // Reset during the division by 3, then a clean rerun.
    sb.push_back(16'd13); sb.push_back(16'd17);
    start(16'd221);
    repeat (22) @(negedge clk);
    check("pre_abort_valid", bus.valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("abort_ready", bus.ready, 1);
    check("abort_valid", bus.valid, 0);
    check("abort_done", bus.done, 0);
    check("abort_error", bus.error, 0);
    $display("reset during division of n=221");
    repeat (40) @(negedge clk);
    check("abort_quiet_valid", bus.valid, 0);
    check("abort_quiet_ready", bus.ready, 1);

    sb.push_back(16'd13); sb.push_back(16'd17);
    start(16'd221);
    collect(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
